// File: rtl/bin_to_bcd_seq_if.sv
// Purpose: bundles the converter's request and result signals into one port group.
// Latency: none (wiring only).
// Backpressure: none; the converter ignores start while busy, so the requester watches busy/done.
//
// Signals:
//   start   - conversion request, sampled by the converter only while idle
//   bin_in  - unsigned binary value, captured on the accepting edge
//   busy    - conversion in progress
//   done    - one-cycle pulse when bcd_out/ovf are updated
//   ovf     - captured value was above 99 (bcd_out shows 8'hFF, i.e. both digits blank)
//   bcd_out - packed BCD result, tens in [7:4], units in [3:0]
interface bin_to_bcd_seq_if #(
    parameter int IN_WIDTH = 7
);
    logic                start;
    logic [IN_WIDTH-1:0] bin_in;
    logic                busy;
    logic                done;
    logic                ovf;
    logic [7:0]          bcd_out;

    // master: the requester / display path side
    modport master (
        output start,
        output bin_in,
        input  busy,
        input  done,
        input  ovf,
        input  bcd_out
    );

    // slave: the converter itself
    modport slave (
        input  start,
        input  bin_in,
        output busy,
        output done,
        output ovf,
        output bcd_out
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Purpose: sequential binary -> two-digit packed BCD converter (shift-and-add-3), one shift per clock.
// Latency: IN_WIDTH+1 edges from the start-sampling edge until the done pulse; busy for IN_WIDTH cycles.
// Backpressure: none; start is ignored while busy (no queuing), results are held until the next completion.
//
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset
//   io  - bin_to_bcd_seq_if.slave: start, bin_in in; busy, done, ovf, bcd_out out
module bin_to_bcd_seq #(
    parameter int IN_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    bin_to_bcd_seq_if.slave       io
);

    localparam int CNT_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t              state_q,   state_d;
    logic [IN_WIDTH-1:0] bin_q,     bin_d;      // captured value, shifted out MSB first
    logic [7:0]          acc_q,     acc_d;      // two-digit BCD accumulator
    logic [CNT_W-1:0]    cnt_q,     cnt_d;
    logic                big_q,     big_d;      // captured value exceeds 99
    logic [7:0]          bcd_out_q, bcd_out_d;
    logic                ovf_q,     ovf_d;
    logic                done_q,    done_d;

    logic [7:0] bin_ext;
    logic [7:0] acc_adj;
    logic [7:0] acc_shift;

    // Overflow is judged from the input value, since the accumulator drops the hundreds carry.
    assign bin_ext = 8'(io.bin_in);

    // Add-3 correction on each digit before the shift so it doubles into a valid BCD digit.
    assign acc_adj[3:0] = (acc_q[3:0] >= 4'd5) ? acc_q[3:0] + 4'd3 : acc_q[3:0];
    assign acc_adj[7:4] = (acc_q[7:4] >= 4'd5) ? acc_q[7:4] + 4'd3 : acc_q[7:4];

    // Shift {acc, bin} left by one; the bit leaving acc[7] is the discarded hundreds carry.
    assign acc_shift = {acc_adj[6:0], bin_q[IN_WIDTH-1]};

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        big_d     = big_q;
        bcd_out_d = bcd_out_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (io.start) begin
                    bin_d   = io.bin_in;
                    acc_d   = 8'h00;
                    cnt_d   = '0;
                    big_d   = (bin_ext > 8'd99);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                acc_d = acc_shift;
                bin_d = bin_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    // Last shift: publish the post-shift value, or blank both digits on overflow.
                    bcd_out_d = big_q ? 8'hFF : acc_shift;
                    ovf_d     = big_q;
                    done_d    = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bin_q     <= '0;
            acc_q     <= 8'h00;
            cnt_q     <= '0;
            big_q     <= 1'b0;
            bcd_out_q <= 8'h00;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            big_q     <= big_d;
            bcd_out_q <= bcd_out_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    // The state register is itself a flop, so busy is registered.
    assign io.busy    = (state_q == ST_SHIFT);
    assign io.done    = done_q;
    assign io.ovf     = ovf_q;
    assign io.bcd_out = bcd_out_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;

    localparam int IN_WIDTH = 7;

    logic clk;
    logic rst;

    bin_to_bcd_seq_if #(.IN_WIDTH(IN_WIDTH)) io ();

    bin_to_bcd_seq #(.IN_WIDTH(IN_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Expected results in completion order: {ovf, bcd[7:0]}
    logic [8:0] sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: decimal digits by division, blank (FF) above 99.
    function automatic logic [8:0] model(input int v);
        if (v > 99) return {1'b1, 8'hFF};
        return {1'b0, 4'(v / 10), 4'(v % 10)};
    endfunction

    // Waits (bounded) for a done pulse, sampling on negedges.
    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!io.done && n < 40);
        check("done_timeout", 32'(io.done), 32'd1);
    endtask

    // Issue one conversion; returns at the negedge of the done cycle.
    task automatic convert(input int v);
        io.start  = 1'b1;
        io.bin_in = 7'(v);
        sb.push_back(model(v));
        @(negedge clk);
        io.start  = 1'b0;
        io.bin_in = 7'($urandom);
        wait_done();
    endtask

    // Monitor: compares results at done, checks stability, busy length and done timing.
    initial begin
        logic [7:0] last_bcd;
        logic       last_ovf;
        logic       prev_busy;
        int         busy_cnt;
        logic [8:0] exp;
        last_bcd  = 8'h00;
        last_ovf  = 1'b0;
        prev_busy = 1'b0;
        busy_cnt  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                last_bcd  = 8'h00;
                last_ovf  = 1'b0;
                prev_busy = 1'b0;
                busy_cnt  = 0;
            end else begin
                check("done_timing", 32'(io.done), 32'(prev_busy && !io.busy));
                if (io.done) begin
                    check("sb_nonempty_at_done", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        exp = sb.pop_front();
                        check("bcd_out", 32'(io.bcd_out), 32'(exp[7:0]));
                        check("ovf", 32'(io.ovf), 32'(exp[8]));
                        last_bcd = exp[7:0];
                        last_ovf = exp[8];
                    end
                end else begin
                    check("bcd_out_held", 32'(io.bcd_out), 32'(last_bcd));
                    check("ovf_held", 32'(io.ovf), 32'(last_ovf));
                end
                if (io.busy) begin
                    busy_cnt++;
                end else if (busy_cnt != 0) begin
                    check("busy_cycles", 32'(busy_cnt), 32'(IN_WIDTH));
                    busy_cnt = 0;
                end
                prev_busy = io.busy;
            end
        end
    end

    // Stimulus
    initial begin
        int gap;
        int vals[7] = '{57, 0, 9, 10, 99, 100, 127};

        rst       = 1'b1;
        io.start  = 1'b0;
        io.bin_in = '0;
        repeat (3) @(negedge clk);
        check("rst_bcd_out", 32'(io.bcd_out), 32'h00);
        check("rst_busy", 32'(io.busy), 32'd0);
        check("rst_done", 32'(io.done), 32'd0);
        check("rst_ovf", 32'(io.ovf), 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("idle_bcd_out", 32'(io.bcd_out), 32'h00);
        check("idle_busy", 32'(io.busy), 32'd0);

        // Directed values, including the 99/100 boundary and the maximum input
        foreach (vals[i]) begin
            convert(vals[i]);
            repeat (2) @(negedge clk);
        end
        convert(42);
        @(negedge clk);
        check("after_ovf_clear", 32'(io.ovf), 32'd0);

        // Random conversions, random gaps (gap 0 starts in the done cycle)
        for (int i = 0; i < 30; i++) begin
            convert(int'($urandom_range(0, 127)));
            gap = int'($urandom_range(0, 3));
            repeat (gap) @(negedge clk);
        end

        // start held high; bin_in changes mid-conversion
        @(negedge clk);
        io.start  = 1'b1;
        io.bin_in = 7'd23;
        sb.push_back(model(23));
        repeat (3) @(negedge clk);
        io.bin_in = 7'd61;
        sb.push_back(model(61));
        wait_done();
        gap = 0;
        @(negedge clk);
        gap++;
        io.start = 1'b0;
        do begin
            @(negedge clk);
            gap++;
        end while (!io.done && gap < 40);
        check("done_spacing", 32'(gap), 32'd8);
        repeat (2) @(negedge clk);

        // Reset mid-conversion
        convert(88);
        @(negedge clk);
        io.start  = 1'b1;
        io.bin_in = 7'd34;
        sb.push_back(model(34));
        @(negedge clk);
        io.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        #1;
        check("abort_bcd_out", 32'(io.bcd_out), 32'h00);
        check("abort_busy", 32'(io.busy), 32'd0);
        check("abort_done", 32'(io.done), 32'd0);
        check("abort_ovf", 32'(io.ovf), 32'd0);
        repeat (2) @(negedge clk);
        check("abort_no_done", 32'(io.done), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        convert(34);
        repeat (3) @(negedge clk);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
